// File: rtl/decode_pkg.sv
// decode_pkg
//   Shared types and constants for the RV32I decode/control stage.
//   - alu_op_e     : ALU operation encoding driven onto ALUControl
//   - imm_src_e    : immediate format select (I/S/B/U/J)
//   - result_src_e : write-back source select (ALU / memory / PC+4)
//   - OPC_*        : RV32I major opcodes (full 7 bits, so instr[1:0]==2'b11 is implied)
//   - ctrl_bundle_t: the registered control bundle handed to execute
package decode_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLL   = 4'd6,
        ALU_SRL   = 4'd7,
        ALU_SRA   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        logic        jalr_sel;
        logic        alu_src_a_pc;
        result_src_e result_src;
        imm_src_e    imm_src;
        alu_op_e     alu_ctrl;
        logic [2:0]  funct3;
        logic        illegal;
    } ctrl_bundle_t;

    // Shared by R-type and I-ALU: funct3 selects the operation, 'alt'
    // (funct7[5] / instr[30]) picks SUB over ADD and SRA over SRL.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_ctrl_stage_comb.sv
// decode_comb
//   Pure combinational RV32I decoder: raw instruction word -> control bundle.
//   Ports:
//     instr_i : 32-bit instruction word
//     ctrl_o  : decoded ctrl_bundle_t; an unrecognised encoding yields an
//               all-zero bundle with only .illegal set
//   EN_RTYPE = 0 makes opcode 0110011 decode as illegal.
module decode_comb
    import decode_pkg::*;
#(
    parameter bit EN_RTYPE = 1'b1
) (
    input  logic [31:0]  instr_i,
    output ctrl_bundle_t ctrl_o
);

    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic         legal;
    ctrl_bundle_t ctrl;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    // Register specifiers and rd are not needed for control decode.
    logic unused_fields;
    assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

    always_comb begin
        ctrl  = '0;
        legal = 1'b0;

        case (opcode)
            OPC_RTYPE: begin
                if (EN_RTYPE) begin
                    // Only add/sub and srl/sra have an alternate funct7 encoding.
                    legal = (funct7 == FUNCT7_BASE) ||
                            ((funct7 == FUNCT7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_ctrl  = alu_from_funct3(funct3, funct7[5]);
                end
            end
            OPC_IALU: begin
                // Shift-immediates reuse instr[31:25] as a funct7 field; every
                // other I-ALU op treats those bits as immediate.
                if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
                    legal = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
                end else begin
                    legal = 1'b1;
                end
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_src   = IMM_I;
                // instr[30] only selects SRAI; for addi it is immediate data.
                ctrl.alu_ctrl  = alu_from_funct3(funct3, (funct3 == 3'b101) && instr_i[30]);
            end
            OPC_LOAD: begin
                legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.imm_src    = IMM_I;
                ctrl.result_src = RES_MEM;
                ctrl.alu_ctrl   = ALU_ADD;
            end
            OPC_STORE: begin
                legal = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
                ctrl.mem_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.imm_src    = IMM_S;
                ctrl.result_src = RES_MEM;
                ctrl.alu_ctrl   = ALU_ADD;
            end
            OPC_BRANCH: begin
                legal = (funct3 != 3'b010) && (funct3 != 3'b011);
                ctrl.branch   = 1'b1;
                ctrl.imm_src  = IMM_B;
                // Comparison is resolved in execute from funct3_q; SUB feeds it.
                ctrl.alu_ctrl = ALU_SUB;
            end
            OPC_JAL: begin
                legal = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.imm_src    = IMM_J;
                ctrl.result_src = RES_PC4;
                ctrl.alu_ctrl   = ALU_ADD;
            end
            OPC_JALR: begin
                legal = (funct3 == 3'b000);
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.jalr_sel   = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.imm_src    = IMM_I;
                ctrl.result_src = RES_PC4;
                ctrl.alu_ctrl   = ALU_ADD;
            end
            OPC_LUI: begin
                legal = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_src   = IMM_U;
                ctrl.alu_ctrl  = ALU_PASSB;
            end
            OPC_AUIPC: begin
                legal = 1'b1;
                ctrl.reg_write    = 1'b1;
                ctrl.alu_src      = 1'b1;
                ctrl.alu_src_a_pc = 1'b1;
                ctrl.imm_src      = IMM_U;
                ctrl.alu_ctrl     = ALU_ADD;
            end
            default: begin
                legal = 1'b0;
            end
        endcase

        if (legal) begin
            ctrl.funct3 = funct3;
        end else begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
        end

        ctrl_o = ctrl;
    end

endmodule

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage
//   Registered RV32I decode/control stage between IF/ID and execute.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     in_valid/in_ready   : upstream handshake, instr is the payload
//     flush               : kills the held bundle and any incoming instr
//     clear_stats         : clears illegal_seen / ill_count
//     out_valid/out_ready : downstream handshake for the control bundle
//     RegWrite..ALUSrcA_pc, ResultSrc, ImmSrc, ALUControl, funct3_q, illegal
//                         : registered control bundle
//     illegal_seen        : sticky "an illegal instruction was accepted"
//     ill_count           : saturating count of accepted illegal instructions
//   ALUCTRL_W must be at least 4 (the ALU op enum is 4 bits, zero-extended).
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready = !out_valid || out_ready, so the single register is refilled in
// the same cycle it drains (no skid buffer). While out_valid && !out_ready the
// bundle is frozen. flush wins over an accept: the register empties and the
// incoming word is dropped without touching the statistics. Bundle fields keep
// their last loaded value when out_valid is low.
module decode_ctrl_stage
    import decode_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 4,
    parameter int unsigned ILL_CNT_W = 8,
    parameter bit          EN_RTYPE  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic                 flush,
    input  logic                 clear_stats,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 Jump,
    output logic                 Branch,
    output logic                 ALUSrc,
    output logic                 JalrmuxSel,
    output logic                 ALUSrcA_pc,
    output logic [1:0]           ResultSrc,
    output logic [2:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [2:0]           funct3_q,
    output logic                 illegal,
    output logic                 illegal_seen,
    output logic [ILL_CNT_W-1:0] ill_count
);

    ctrl_bundle_t         dec_ctrl;
    ctrl_bundle_t         bundle_q, bundle_d;
    logic                 valid_q, valid_d;
    logic                 seen_q, seen_d;
    logic [ILL_CNT_W-1:0] cnt_q, cnt_d;
    logic                 accept;

    decode_comb #(
        .EN_RTYPE (EN_RTYPE)
    ) u_decode_comb (
        .instr_i (instr),
        .ctrl_o  (dec_ctrl)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            bundle_d = dec_ctrl;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        seen_d = seen_q;
        cnt_d  = cnt_q;
        if (clear_stats) begin
            seen_d = 1'b0;
            cnt_d  = '0;
        end else if (accept && !flush && dec_ctrl.illegal) begin
            seen_d = 1'b1;
            if (cnt_q != {ILL_CNT_W{1'b1}}) begin
                cnt_d = cnt_q + ILL_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
            seen_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
            seen_q   <= seen_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid    = valid_q;
    assign RegWrite     = bundle_q.reg_write;
    assign MemWrite     = bundle_q.mem_write;
    assign Jump         = bundle_q.jump;
    assign Branch       = bundle_q.branch;
    assign ALUSrc       = bundle_q.alu_src;
    assign JalrmuxSel   = bundle_q.jalr_sel;
    assign ALUSrcA_pc   = bundle_q.alu_src_a_pc;
    assign ResultSrc    = bundle_q.result_src;
    assign ImmSrc       = bundle_q.imm_src;
    assign ALUControl   = ALUCTRL_W'(bundle_q.alu_ctrl);
    assign funct3_q     = bundle_q.funct3;
    assign illegal      = bundle_q.illegal;
    assign illegal_seen = seen_q;
    assign ill_count    = cnt_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb_decode_ctrl_stage
//   Directed steps followed by randomized traffic, every output compared each
//   cycle against a reference model derived from the RV32I rules.
module tb_decode_ctrl_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        flush;
    logic        clear_stats;
    logic        out_valid;
    logic        out_ready;
    logic        RegWrite, MemWrite, Jump, Branch, ALUSrc, JalrmuxSel, ALUSrcA_pc;
    logic [1:0]  ResultSrc;
    logic [2:0]  ImmSrc;
    logic [3:0]  ALUControl;
    logic [2:0]  funct3_q;
    logic        illegal;
    logic        illegal_seen;
    logic [7:0]  ill_count;

    int checks = 0;
    int errors = 0;

    decode_ctrl_stage #(
        .ALUCTRL_W (4),
        .ILL_CNT_W (8),
        .EN_RTYPE  (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .flush        (flush),
        .clear_stats  (clear_stats),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .RegWrite     (RegWrite),
        .MemWrite     (MemWrite),
        .Jump         (Jump),
        .Branch       (Branch),
        .ALUSrc       (ALUSrc),
        .JalrmuxSel   (JalrmuxSel),
        .ALUSrcA_pc   (ALUSrcA_pc),
        .ResultSrc    (ResultSrc),
        .ImmSrc       (ImmSrc),
        .ALUControl   (ALUControl),
        .funct3_q     (funct3_q),
        .illegal      (illegal),
        .illegal_seen (illegal_seen),
        .ill_count    (ill_count)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model
    typedef struct packed {
        logic       rw, mw, jmp, br, asrc, jsel, apc;
        logic [1:0] rs;
        logic [2:0] imm;
        logic [3:0] alu;
        logic [2:0] f3;
        logic       ill;
    } exp_t;

    exp_t       m_b;
    logic       m_valid;
    logic       m_seen;
    logic [7:0] m_cnt;

    // ALU codes: ADD0 SUB1 AND2 OR3 XOR4 SLT5 SLL6 SRL7 SRA8 SLTU9 PASSB10
    function automatic exp_t model(input logic [31:0] ins);
        exp_t       e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       ok;
        logic [3:0] base_alu [8];
        logic [7:0] load_ok;
        logic [7:0] store_ok;
        logic [7:0] br_ok;
        base_alu = '{4'd0, 4'd6, 4'd5, 4'd9, 4'd4, 4'd7, 4'd3, 4'd2};
        load_ok  = 8'b0011_0111;
        store_ok = 8'b0000_0111;
        br_ok    = 8'b1111_0011;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        e  = '0;
        ok = 1'b0;
        if (op == 7'h33) begin
            ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            e.rw  = 1'b1;
            e.alu = base_alu[f3];
            if (f7 == 7'h20) e.alu = (f3 == 3'd0) ? 4'd1 : 4'd8;
        end else if (op == 7'h13) begin
            ok = !(f3 == 3'd1 || f3 == 3'd5) || f7 == 7'h00 || f7 == 7'h20;
            e.rw = 1'b1; e.asrc = 1'b1; e.imm = 3'd0;
            e.alu = base_alu[f3];
            if (f3 == 3'd5 && ins[30]) e.alu = 4'd8;
        end else if (op == 7'h03) begin
            ok = load_ok[f3];
            e.rw = 1'b1; e.asrc = 1'b1; e.imm = 3'd0; e.rs = 2'd1; e.alu = 4'd0;
        end else if (op == 7'h23) begin
            ok = store_ok[f3];
            e.mw = 1'b1; e.asrc = 1'b1; e.imm = 3'd1; e.rs = 2'd1; e.alu = 4'd0;
        end else if (op == 7'h63) begin
            ok = br_ok[f3];
            e.br = 1'b1; e.imm = 3'd2; e.alu = 4'd1;
        end else if (op == 7'h6F) begin
            ok = 1'b1;
            e.rw = 1'b1; e.jmp = 1'b1; e.imm = 3'd4; e.rs = 2'd2; e.alu = 4'd0;
        end else if (op == 7'h67) begin
            ok = (f3 == 3'd0);
            e.rw = 1'b1; e.jmp = 1'b1; e.jsel = 1'b1; e.asrc = 1'b1;
            e.imm = 3'd0; e.rs = 2'd2; e.alu = 4'd0;
        end else if (op == 7'h37) begin
            ok = 1'b1;
            e.rw = 1'b1; e.asrc = 1'b1; e.imm = 3'd3; e.alu = 4'd10;
        end else if (op == 7'h17) begin
            ok = 1'b1;
            e.rw = 1'b1; e.asrc = 1'b1; e.apc = 1'b1; e.imm = 3'd3; e.alu = 4'd0;
        end
        if (ok) begin
            e.f3 = f3;
        end else begin
            e     = '0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [9];
        logic [6:0]  op;
        logic [6:0]  f7;
        logic [31:0] r;
        int          pick;
        int          sel;
        ops  = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        r    = $urandom;
        pick = $urandom_range(0, 10);
        op   = (pick < 9) ? ops[pick] : r[6:0];
        sel  = $urandom_range(0, 3);
        f7   = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : r[31:25];
        return {f7, r[24:7], op};
    endfunction

    // Scoreboard comparison
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":out_valid"},    32'(out_valid),    32'(m_valid));
        chk({tag, ":in_ready"},     32'(in_ready),     32'(!m_valid || out_ready));
        chk({tag, ":RegWrite"},     32'(RegWrite),     32'(m_b.rw));
        chk({tag, ":MemWrite"},     32'(MemWrite),     32'(m_b.mw));
        chk({tag, ":Jump"},         32'(Jump),         32'(m_b.jmp));
        chk({tag, ":Branch"},       32'(Branch),       32'(m_b.br));
        chk({tag, ":ALUSrc"},       32'(ALUSrc),       32'(m_b.asrc));
        chk({tag, ":JalrmuxSel"},   32'(JalrmuxSel),   32'(m_b.jsel));
        chk({tag, ":ALUSrcA_pc"},   32'(ALUSrcA_pc),   32'(m_b.apc));
        chk({tag, ":ResultSrc"},    32'(ResultSrc),    32'(m_b.rs));
        chk({tag, ":ImmSrc"},       32'(ImmSrc),       32'(m_b.imm));
        chk({tag, ":ALUControl"},   32'(ALUControl),   32'(m_b.alu));
        chk({tag, ":funct3_q"},     32'(funct3_q),     32'(m_b.f3));
        chk({tag, ":illegal"},      32'(illegal),      32'(m_b.ill));
        chk({tag, ":illegal_seen"}, 32'(illegal_seen), 32'(m_seen));
        chk({tag, ":ill_count"},    32'(ill_count),    32'(m_cnt));
    endtask

    task automatic model_reset();
        m_b     = '0;
        m_valid = 1'b0;
        m_seen  = 1'b0;
        m_cnt   = 8'd0;
    endtask

    // Driver: apply inputs, check in_ready, clock once, advance model, check all.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic ordy,
                         input logic fl, input logic clr, input string tag);
        logic rdy;
        logic acc;
        exp_t nb;
        in_valid    = v;
        instr       = ins;
        out_ready   = ordy;
        flush       = fl;
        clear_stats = clr;
        #1;
        rdy = !m_valid || ordy;
        chk({tag, ":pre_in_ready"}, 32'(in_ready), 32'(rdy));
        acc = v && rdy;
        nb  = model(ins);
        @(posedge clk);
        #1;
        if (clr) begin
            m_seen = 1'b0;
            m_cnt  = 8'd0;
        end else if (acc && !fl && nb.ill) begin
            m_seen = 1'b1;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end
        if (fl) begin
            m_valid = 1'b0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_b     = nb;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        check_all(tag);
    endtask

    initial begin
        in_valid    = 1'b0;
        instr       = 32'h0;
        out_ready   = 1'b0;
        flush       = 1'b0;
        clear_stats = 1'b0;
        rst_n       = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // addi x1,x0,5
        cycle(1'b1, 32'h00500093, 1'b1, 1'b0, 1'b0, "addi");
        chk("addi:out_valid_c", 32'(out_valid),  32'd1);
        chk("addi:RegWrite_c",  32'(RegWrite),   32'd1);
        chk("addi:ALUSrc_c",    32'(ALUSrc),     32'd1);
        chk("addi:ImmSrc_c",    32'(ImmSrc),     32'd0);
        chk("addi:ALU_c",       32'(ALUControl), 32'd0);
        chk("addi:illegal_c",   32'(illegal),    32'd0);

        // sub then lui back-to-back
        cycle(1'b1, 32'h402081B3, 1'b1, 1'b0, 1'b0, "sub");
        chk("sub:ALU_c", 32'(ALUControl), 32'd1);
        cycle(1'b1, 32'h123452B7, 1'b1, 1'b0, 1'b0, "lui");
        chk("lui:ALU_c",    32'(ALUControl), 32'd10);
        chk("lui:ImmSrc_c", 32'(ImmSrc),     32'd3);

        // drain, then sw held under stall for 3 cycles
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, "drain");
        cycle(1'b1, 32'h0020A023, 1'b0, 1'b0, 1'b0, "sw_load");
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'h00500093, 1'b0, 1'b0, 1'b0, "sw_stall");
            chk("sw_stall:in_ready_c",  32'(in_ready),  32'd0);
            chk("sw_stall:MemWrite_c",  32'(MemWrite),  32'd1);
            chk("sw_stall:ImmSrc_c",    32'(ImmSrc),    32'd1);
            chk("sw_stall:ResultSrc_c", 32'(ResultSrc), 32'd1);
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, "sw_release");
        chk("sw_release:out_valid_c", 32'(out_valid), 32'd0);

        // illegal accounting and saturation
        cycle(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, "ill_first");
        chk("ill_first:illegal_c",  32'(illegal),      32'd1);
        chk("ill_first:RegWrite_c", 32'(RegWrite),     32'd0);
        chk("ill_first:MemWrite_c", 32'(MemWrite),     32'd0);
        chk("ill_first:seen_c",     32'(illegal_seen), 32'd1);
        chk("ill_first:count_c",    32'(ill_count),    32'd1);
        for (int i = 1; i < 300; i++) begin
            cycle(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, "ill_run");
        end
        chk("ill_sat:count_c", 32'(ill_count), 32'd255);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, "clear");
        chk("clear:count_c", 32'(ill_count),    32'd0);
        chk("clear:seen_c",  32'(illegal_seen), 32'd0);
        // clear_stats beats a same-cycle illegal accept
        cycle(1'b1, 32'h0, 1'b1, 1'b0, 1'b1, "clear_prio");
        chk("clear_prio:count_c", 32'(ill_count), 32'd0);

        // flush
        cycle(1'b1, 32'h00208463, 1'b1, 1'b1, 1'b0, "beq_flush");
        chk("beq_flush:out_valid_c", 32'(out_valid), 32'd0);
        cycle(1'b1, 32'h000100E7, 1'b1, 1'b0, 1'b0, "jalr");
        chk("jalr:out_valid_c", 32'(out_valid), 32'd1);
        cycle(1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, "jalr_flush");
        chk("jalr_flush:out_valid_c", 32'(out_valid), 32'd0);
        chk("jalr_flush:count_c",     32'(ill_count), 32'd0);

        // asynchronous reset in the middle of a stall
        cycle(1'b1, 32'h0020A023, 1'b1, 1'b0, 1'b0, "pre_rst");
        cycle(1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, "pre_rst_stall");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst:in_ready_c", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 32'h00500093, 1'b1, 1'b0, 1'b0, "post_rst_addi");
        chk("post_rst_addi:out_valid_c", 32'(out_valid), 32'd1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic v, ordy, fl, clr;
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 9) < 7);
            fl   = ($urandom_range(0, 99) < 8);
            clr  = ($urandom_range(0, 99) < 3);
            cycle(v, rand_instr(), ordy, fl, clr, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
